axi_wr_done_tracker: RTL and testbench
======================================

Name: axi_wr_done_tracker

Overview:
- Parametrised, multi-channel successor of the AXI register block's write-done flag logic.
- Per channel, it tracks AW and W handshake completion and issues the B response once both have completed.
- It exports done flags delayed by a configurable number of cycles and keeps a per-channel completed-write counter.
- It sits between the AXI-lite slave front end and the register file; channel c serves register bank c.

Parameters:
- NUM_CH, 4, number of independent write channels (1..16)
- DLY, 1, pipeline depth of the delayed done outputs (1..8)
- CNT_W, 8, width of each per-channel completed-write counter

Ports:
- s_axi_aclk  in  1  clock
- s_axi_areset  in  1  global reset; one clock; reset is synchronous and active-high
- soft_clr  in  NUM_CH  per-channel local clear, active-high, synchronous
- awvalid  in  NUM_CH  AW valid per channel
- awready  out  NUM_CH  AW ready per channel
- wvalid  in  NUM_CH  W valid per channel
- wready  out  NUM_CH  W ready per channel
- wr_slverr  in  NUM_CH  error flag for the address, sampled on the AW handshake
- bvalid  out  NUM_CH  B valid per channel
- bready  in  NUM_CH  B ready per channel
- bresp  out  2*NUM_CH  B response; channel c occupies bits [2c+1:2c]
- awaddr_done  out  NUM_CH  AW completed, current-cycle flag
- wdata_done  out  NUM_CH  W completed, current-cycle flag
- awaddr_done_dly  out  NUM_CH  awaddr_done delayed by DLY cycles
- wdata_done_dly  out  NUM_CH  wdata_done delayed by DLY cycles
- wr_cnt  out  CNT_W*NUM_CH  completed B handshakes per channel, saturating

Behaviour:
- Channel clear is `clr_c = s_axi_areset | soft_clr[c]`, evaluated at the clock edge.
  - Clear is the OR of the two sources, never the AND. Global reset alone always clears every channel.
  - On clear: state IDLE, bvalid=0, bresp=00, err latch=0, all delay stages=0, wr_cnt=0.
  - Outputs derived from state then follow: awaddr_done=0, wdata_done=0, awready=1, wready=1.
- Per-channel FSM states: IDLE, AW_DONE, W_DONE, RESP.
  - IDLE: AW handshake only -> AW_DONE; W handshake only -> W_DONE; both in the same cycle -> RESP.
  - AW_DONE: W handshake -> RESP.
  - W_DONE: AW handshake -> RESP.
  - RESP: bvalid=1; bready -> IDLE.
- Handshakes:
  - AW handshake = awvalid & awready.
  - W handshake = wvalid & wready.
- Ready and done outputs (combinational from state):
  - awready=1 only in IDLE and W_DONE.
  - wready=1 only in IDLE and AW_DONE.
  - awaddr_done=1 in AW_DONE and RESP.
  - wdata_done=1 in W_DONE and RESP.
- B channel timing and content:
  - bvalid rises the cycle after the last of the two handshakes.
  - bvalid holds until bready; bresp stays stable while bvalid=1.
  - bresp = 10 (SLVERR) if wr_slverr was 1 at the AW handshake, else 00 (OKAY).
- wr_cnt[c] increments on each bvalid & bready and saturates at 2^CNT_W-1, no wrap.
- Delayed outputs:
  - *_dly = the value of the corresponding done flag exactly DLY cycles earlier, via a DLY-stage shift register.
  - The shift register is cleared with the channel.
- Mid-transaction clear: a soft_clr in RESP drops bvalid the next cycle without counting. The master sees the write aborted.
- Channel independence: channels share no state; a clear on channel c leaves all other channels untouched.

Decomposition:
- Shared package axi_wr_pkg holds:
  - `wr_state_e` (IDLE, AW_DONE, W_DONE, RESP)
  - `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10
  - `MAX_CH`=16 and `MAX_DLY`=8
- One sub-module, axi_wr_done_ch: a single channel (FSM, err latch, delay line, counter). The top instantiates it NUM_CH times via generate.

Test Plan:
- Assert s_axi_areset 2 cycles mid-RESP -> all outputs at clear values the next cycle, wr_cnt=0.
- Channel 0: AW at cycle 5, W at cycle 8, bready held 1 -> bvalid=1 at cycle 9 only; bresp=00; wr_cnt[0]=1; awaddr_done_dly with DLY=3 rises at cycle 9.
- Channel 1: AW and W in the same cycle with wr_slverr=1 -> bvalid next cycle, bresp=10.
- Backpressure: bready=0 for 10 cycles -> bvalid and bresp stable; awready=wready=0 throughout.
- soft_clr[2] pulsed while in AW_DONE, channel 3 mid-write -> channel 2 back to IDLE, channel 3 completes normally.
- CNT_W=2: 5 back-to-back writes -> wr_cnt saturates at 3.

Source files
------------

// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the multi-channel AXI write-done tracker.
package axi_wr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    AW_DONE = 2'd1,
    W_DONE  = 2'd2,
    RESP    = 2'd3
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned MAX_CH  = 16;
  localparam int unsigned MAX_DLY = 8;

endpackage

// File: rtl/axi_wr_done_ch.sv
// One write channel: AW/W completion FSM, error latch, delayed done flags and a
// saturating completed-write counter.
module axi_wr_done_ch
  import axi_wr_pkg::*;
#(
  parameter int unsigned DLY   = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             s_axi_aclk,
  input  logic             clr,
  input  logic             awvalid,
  output logic             awready,
  input  logic             wvalid,
  output logic             wready,
  input  logic             wr_slverr,
  output logic             bvalid,
  input  logic             bready,
  output logic [1:0]       bresp,
  output logic             awaddr_done,
  output logic             wdata_done,
  output logic             awaddr_done_dly,
  output logic             wdata_done_dly,
  output logic [CNT_W-1:0] wr_cnt
);

  wr_state_e        state_q, state_d;
  logic             err_q, err_d;
  logic [DLY-1:0]   aw_dly_q, w_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aw_hs, w_hs, b_hs;

  always_comb begin
    awready     = (state_q == IDLE) || (state_q == W_DONE);
    wready      = (state_q == IDLE) || (state_q == AW_DONE);
    awaddr_done = (state_q == AW_DONE) || (state_q == RESP);
    wdata_done  = (state_q == W_DONE) || (state_q == RESP);
    bvalid      = (state_q == RESP);
    // err_q cannot change while in RESP (awready is low), so bresp is stable.
    bresp       = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
  end

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) begin
          state_d = RESP;
        end else if (aw_hs) begin
          state_d = AW_DONE;
        end else if (w_hs) begin
          state_d = W_DONE;
        end
      end
      AW_DONE: if (w_hs)   state_d = RESP;
      W_DONE:  if (aw_hs)  state_d = RESP;
      RESP:    if (bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d = aw_hs ? wr_slverr : err_q;
    cnt_d = cnt_q;
    if (b_hs && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (clr) begin
      state_q  <= IDLE;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      aw_dly_q <= '0;
      w_dly_q  <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      aw_dly_q[0] <= awaddr_done;
      w_dly_q[0]  <= wdata_done;
      for (int i = 1; i < int'(DLY); i++) begin
        aw_dly_q[i] <= aw_dly_q[i-1];
        w_dly_q[i]  <= w_dly_q[i-1];
      end
    end
  end

  assign awaddr_done_dly = aw_dly_q[DLY-1];
  assign wdata_done_dly  = w_dly_q[DLY-1];
  assign wr_cnt          = cnt_q;

endmodule

// File: rtl/axi_wr_done_tracker.sv
// Multi-channel AXI write-done tracker; channel c serves register bank c and is
// cleared by the global reset or its own soft clear.
module axi_wr_done_tracker #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DLY    = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [NUM_CH-1:0]       soft_clr,
  input  logic [NUM_CH-1:0]       awvalid,
  output logic [NUM_CH-1:0]       awready,
  input  logic [NUM_CH-1:0]       wvalid,
  output logic [NUM_CH-1:0]       wready,
  input  logic [NUM_CH-1:0]       wr_slverr,
  output logic [NUM_CH-1:0]       bvalid,
  input  logic [NUM_CH-1:0]       bready,
  output logic [2*NUM_CH-1:0]     bresp,
  output logic [NUM_CH-1:0]       awaddr_done,
  output logic [NUM_CH-1:0]       wdata_done,
  output logic [NUM_CH-1:0]       awaddr_done_dly,
  output logic [NUM_CH-1:0]       wdata_done_dly,
  output logic [CNT_W*NUM_CH-1:0] wr_cnt
);

  logic [NUM_CH-1:0] ch_clr;

  assign ch_clr = soft_clr | {NUM_CH{s_axi_areset}};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    axi_wr_done_ch #(
      .DLY   (DLY),
      .CNT_W (CNT_W)
    ) u_ch (
      .s_axi_aclk      (s_axi_aclk),
      .clr             (ch_clr[c]),
      .awvalid         (awvalid[c]),
      .awready         (awready[c]),
      .wvalid          (wvalid[c]),
      .wready          (wready[c]),
      .wr_slverr       (wr_slverr[c]),
      .bvalid          (bvalid[c]),
      .bready          (bready[c]),
      .bresp           (bresp[2*c +: 2]),
      .awaddr_done     (awaddr_done[c]),
      .wdata_done      (wdata_done[c]),
      .awaddr_done_dly (awaddr_done_dly[c]),
      .wdata_done_dly  (wdata_done_dly[c]),
      .wr_cnt          (wr_cnt[CNT_W*c +: CNT_W])
    );
  end

endmodule

// File: tb/tb_axi_wr_done_tracker.sv
// Scoreboard bench for axi_wr_done_tracker: directed scenarios then random traffic,
// checked every cycle against a transaction-level model.
module tb_axi_wr_done_tracker;

  localparam int NUM_CH  = 4;
  localparam int DLY     = 3;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int LOGN    = 4096;

  logic                    clk = 1'b0;
  logic                    s_axi_areset;
  logic [NUM_CH-1:0]       soft_clr, awvalid, wvalid, wr_slverr, bready;
  logic [NUM_CH-1:0]       awready, wready, bvalid;
  logic [NUM_CH-1:0]       awaddr_done, wdata_done, awaddr_done_dly, wdata_done_dly;
  logic [2*NUM_CH-1:0]     bresp;
  logic [CNT_W*NUM_CH-1:0] wr_cnt;

  always #5 clk = ~clk;

  axi_wr_done_tracker #(
    .NUM_CH (NUM_CH),
    .DLY    (DLY),
    .CNT_W  (CNT_W)
  ) dut (
    .s_axi_aclk      (clk),
    .s_axi_areset    (s_axi_areset),
    .soft_clr        (soft_clr),
    .awvalid         (awvalid),
    .awready         (awready),
    .wvalid          (wvalid),
    .wready          (wready),
    .wr_slverr       (wr_slverr),
    .bvalid          (bvalid),
    .bready          (bready),
    .bresp           (bresp),
    .awaddr_done     (awaddr_done),
    .wdata_done      (wdata_done),
    .awaddr_done_dly (awaddr_done_dly),
    .wdata_done_dly  (wdata_done_dly),
    .wr_cnt          (wr_cnt)
  );

  typedef struct packed {
    logic [3:0] ch;
    logic [1:0] resp;
  } exp_t;

  exp_t sb[$];

  // Transaction-level model: which halves of the current write have been accepted,
  // whether a response is owed, and how many writes have completed.
  bit m_aw   [NUM_CH];
  bit m_w    [NUM_CH];
  bit m_resp [NUM_CH];
  bit m_err  [NUM_CH];
  int m_cnt  [NUM_CH];
  int last_clr [NUM_CH];
  bit log_aw [NUM_CH][LOGN];
  bit log_w  [NUM_CH][LOGN];
  int cyc = 0;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int c, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s ch%0d cycle %0d: got %0d, expected %0d", name, c, cyc, act, exp);
    end
  endtask

  function automatic void drop_exp(input int c);
    for (int i = 0; i < sb.size(); i++) begin
      if (int'(sb[i].ch) == c) begin
        sb.delete(i);
        return;
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      bit clr, awhs, whs, bhs;
      clr = s_axi_areset | soft_clr[c];
      if (clr) begin
        if (m_resp[c]) drop_exp(c);
        m_aw[c] = 0; m_w[c] = 0; m_resp[c] = 0; m_err[c] = 0; m_cnt[c] = 0;
        last_clr[c] = cyc + 1;
      end else begin
        awhs = awvalid[c] && !m_aw[c];
        whs  = wvalid[c] && !m_w[c];
        bhs  = m_resp[c] && bready[c];
        if (bhs) begin
          m_aw[c] = 0; m_w[c] = 0; m_resp[c] = 0;
          if (m_cnt[c] < CNT_MAX) m_cnt[c]++;
        end else begin
          if (awhs) begin
            m_aw[c]  = 1;
            m_err[c] = wr_slverr[c];
          end
          if (whs) m_w[c] = 1;
          if (m_aw[c] && m_w[c] && !m_resp[c]) begin
            m_resp[c] = 1;
            sb.push_back('{ch: 4'(c), resp: (m_err[c] ? 2'b10 : 2'b00)});
          end
        end
      end
    end
    cyc++;
    for (int c = 0; c < NUM_CH; c++) begin
      log_aw[c][cyc % LOGN] = m_aw[c];
      log_w[c][cyc % LOGN]  = m_w[c];
    end
  end

  // Monitor: compares every channel each cycle; B responses come off the scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        int e_adly, e_wdly, idx;
        bit real_hs;
        e_adly = 0;
        e_wdly = 0;
        if (cyc - last_clr[c] >= DLY) begin
          e_adly = int'(log_aw[c][(cyc - DLY) % LOGN]);
          e_wdly = int'(log_w[c][(cyc - DLY) % LOGN]);
        end
        chk("awready", c, int'(awready[c]), int'(!m_aw[c]));
        chk("wready", c, int'(wready[c]), int'(!m_w[c]));
        chk("awaddr_done", c, int'(awaddr_done[c]), int'(m_aw[c]));
        chk("wdata_done", c, int'(wdata_done[c]), int'(m_w[c]));
        chk("awaddr_done_dly", c, int'(awaddr_done_dly[c]), e_adly);
        chk("wdata_done_dly", c, int'(wdata_done_dly[c]), e_wdly);
        chk("bvalid", c, int'(bvalid[c]), int'(m_resp[c]));
        chk("wr_cnt", c, int'(wr_cnt[CNT_W*c +: CNT_W]), m_cnt[c]);
        if (bvalid[c]) begin
          idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && int'(sb[i].ch) == c) idx = i;
          end
          if (idx < 0) begin
            chk("bresp_unexpected", c, int'(bresp[2*c +: 2]), -1);
          end else begin
            chk("bresp", c, int'(bresp[2*c +: 2]), int'(sb[idx].resp));
            real_hs = bready[c] && !s_axi_areset && !soft_clr[c];
            if (real_hs) sb.delete(idx);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    awvalid = '0; wvalid = '0; wr_slverr = '0; soft_clr = '0;
  endtask

  initial begin
    s_axi_areset = 1'b1;
    soft_clr = '0; awvalid = '0; wvalid = '0; wr_slverr = '0; bready = '0;
    repeat (2) tick();
    chk_en = 1'b1;
    s_axi_areset = 1'b0;
    tick();

    // Channel 0: AW, then W three cycles later, bready held high.
    bready = '1;
    awvalid[0] = 1'b1; tick(); quiet();
    repeat (2) tick();
    wvalid[0] = 1'b1; tick(); quiet();
    repeat (5) tick();

    // Channel 1: AW and W together with an address error.
    awvalid[1] = 1'b1; wvalid[1] = 1'b1; wr_slverr[1] = 1'b1; tick(); quiet();
    repeat (3) tick();

    // Backpressure on channel 1.
    bready[1] = 1'b0;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1; wr_slverr[1] = 1'b1; tick(); quiet();
    repeat (10) tick();
    bready[1] = 1'b1; tick();
    tick();

    // Soft clear of channel 2 in AW_DONE while channel 3 finishes its write.
    awvalid[2] = 1'b1; awvalid[3] = 1'b1; tick(); quiet();
    tick();
    soft_clr[2] = 1'b1; wvalid[3] = 1'b1; tick(); quiet();
    repeat (5) tick();

    // Five back-to-back writes on channel 0 saturate its 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      awvalid[0] = 1'b1; wvalid[0] = 1'b1; tick(); quiet();
      tick();
    end
    tick();
    chk("sat_cnt", 0, int'(wr_cnt[CNT_W-1:0]), 3);

    // Global reset held two cycles while channel 0 is in RESP.
    bready = '0;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; tick(); quiet();
    tick();
    s_axi_areset = 1'b1; tick(); tick();
    s_axi_areset = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      chk("rst_bvalid", c, int'(bvalid[c]), 0);
      chk("rst_cnt", c, int'(wr_cnt[CNT_W*c +: CNT_W]), 0);
      chk("rst_awready", c, int'(awready[c]), 1);
    end
    tick();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      awvalid   = NUM_CH'($urandom);
      wvalid    = NUM_CH'($urandom);
      wr_slverr = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) bready[c] = ($urandom_range(0, 9) < 7);
      soft_clr  = ($urandom_range(0, 40) == 0) ? NUM_CH'(1 << $urandom_range(0, NUM_CH-1)) : '0;
      s_axi_areset = ($urandom_range(0, 300) == 0);
      tick();
    end
    quiet();
    s_axi_areset = 1'b0;
    bready = '1;
    repeat (DLY + 4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
